// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg: shared widths and feeder state encoding for the MAC chain slice.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_feeder_if.sv
// ----------------------------------------------------------------------------
// mac_feeder_if: operand-source handshake plus the MAC-chain input bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_feeder_if #(
  parameter int ROWS   = 8,
  parameter int DATA_W = 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_a;
  logic [DATA_W-1:0]        in_b;
  logic                     clr_out;
  logic                     en_out;
  logic [DATA_W-1:0]        b_out;
  logic [ROWS*DATA_W-1:0]   a_out;

  // master is the feeder; slave is the source/chain side.
  modport master (
    input  in_valid, in_a, in_b,
    output in_ready, clr_out, en_out, b_out, a_out
  );

  modport slave (
    output in_valid, in_a, in_b,
    input  in_ready, clr_out, en_out, b_out, a_out
  );

endinterface

`default_nettype wire

// File: rtl/mac_skew_line.sv
// ----------------------------------------------------------------------------
// mac_skew_line: DEPTH-stage delay line aligning one A row with the chain.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_skew_line
  import mac_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = mac_pkg::DATA_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DATA_W-1:0] d,
  output logic      [DATA_W-1:0] q
);

  logic [DATA_W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mac_feeder.sv
// ----------------------------------------------------------------------------
// mac_feeder: clears, streams K skewed beats into a ROWS-long MAC chain,
// drains the chain and pulses done.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_feeder
  import mac_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int K      = 8,
  parameter int DATA_W = mac_pkg::DATA_W
) (
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   start,
  output logic        busy,
  output logic        done,
  mac_feeder_if.master bus
);

  localparam int BEAT_W  = $clog2(K + 1);
  localparam int DRAIN_W = $clog2(ROWS + 1);

  feeder_state_t          r_state;
  logic [BEAT_W-1:0]      r_beat_cnt;
  logic [DRAIN_W-1:0]     r_drain_cnt;
  logic                   r_clr;
  logic                   r_en;
  logic [DATA_W-1:0]      r_b;
  logic                   r_done;
  logic                   w_accept;
  logic [ROWS*DATA_W-1:0] w_a_out;

  assign bus.in_ready = (r_state == STREAM);
  assign w_accept     = (r_state == STREAM) && bus.in_valid;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign bus.clr_out  = r_clr;
  assign bus.en_out   = r_en;
  assign bus.b_out    = r_b;
  assign bus.a_out    = w_a_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_clr       <= 1'b0;
      r_en        <= 1'b0;
      r_b         <= '0;
      r_done      <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_en   <= 1'b0;
      r_b    <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= CLEAR;
            r_clr      <= 1'b1;
            r_beat_cnt <= '0;
          end
        end
        CLEAR: begin
          r_state <= STREAM;
        end
        STREAM: begin
          if (w_accept) begin
            r_en <= 1'b1;
            r_b  <= bus.in_b;
            if (r_beat_cnt == BEAT_W'(K - 1)) begin
              r_state     <= DRAIN;
              r_drain_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // ROWS cycles lets the last beat reach and accumulate in MAC ROWS-1.
          if (r_drain_cnt == DRAIN_W'(ROWS - 1)) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Row r is delayed r+1 edges so it meets en/b after r chain hops.
  // Bubbles and idle cycles inject zeros so the lines stay aligned with en.
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_W-1:0] w_d;
      assign w_d = w_accept ? bus.in_a[r*DATA_W +: DATA_W] : '0;

      mac_skew_line #(
        .DEPTH  (r + 1),
        .DATA_W (DATA_W)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .d   (w_d),
        .q   (w_a_out[r*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire
